// File: rtl/count_issue_queue_if.sv
// rtl/count_issue_queue_if.sv - dual-lane dispatch / single issue bundle for the count issue queue
interface count_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in0_valid;
  logic [31:0]      in0_rs1;
  logic [11:0]      in0_imm;
  logic [TAG_W-1:0] in0_rd;
  logic             in1_valid;
  logic [31:0]      in1_rs1;
  logic [11:0]      in1_imm;
  logic [TAG_W-1:0] in1_rd;
  logic             in_ready;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_a;
  logic [1:0]       out_op;
  logic [TAG_W-1:0] out_rd;
  logic             out_illegal;
  logic [CNT_W-1:0] occupancy;

  // dispatcher / count-unit side
  modport master (
    output in0_valid, in0_rs1, in0_imm, in0_rd,
    output in1_valid, in1_rs1, in1_imm, in1_rd,
    output out_ready,
    input  in_ready, out_valid, out_a, out_op, out_rd, out_illegal, occupancy
  );

  // queue side
  modport slave (
    input  in0_valid, in0_rs1, in0_imm, in0_rd,
    input  in1_valid, in1_rs1, in1_imm, in1_rd,
    input  out_ready,
    output in_ready, out_valid, out_a, out_op, out_rd, out_illegal, occupancy
  );
endinterface

// File: rtl/count_issue_queue.sv
// rtl/count_issue_queue.sv - in-order 2-in/1-out FIFO feeding the Zbb clz/ctz/cpop unit
module count_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  count_issue_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // entry storage
  logic [31:0]      r_a   [DEPTH];
  logic [1:0]       r_op  [DEPTH];
  logic [TAG_W-1:0] r_rd  [DEPTH];
  logic             r_ill [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_occ;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_enq0;
  logic             w_enq1;
  logic             w_deq;
  logic [1:0]       w_enq_cnt;
  logic [PTR_W-1:0] w_wr_ptr1;
  logic             w_ill0;
  logic             w_ill1;

  // Both lanes are accepted or neither, so readiness needs two free slots.
  // Derived only from registered occupancy to keep out_ready off this path.
  assign w_in_ready  = (r_occ <= CNT_W'(DEPTH - 2));
  assign w_out_valid = (r_occ != '0);

  assign w_enq0    = w_in_ready & bus.in0_valid;
  assign w_enq1    = w_in_ready & bus.in1_valid;
  assign w_deq     = w_out_valid & bus.out_ready;
  assign w_enq_cnt = {1'b0, w_enq0} + {1'b0, w_enq1};
  // lane 1 lands behind lane 0, or in lane 0's slot when lane 0 is idle
  assign w_wr_ptr1 = r_wr_ptr + PTR_W'(w_enq0);

  // Only imm[11:2] == 0x180 encodes clz/ctz/cpop; op 11 is reserved.
  assign w_ill0 = (bus.in0_imm[11:2] != 10'b0110000000) | (bus.in0_imm[1:0] == 2'b11);
  assign w_ill1 = (bus.in1_imm[11:2] != 10'b0110000000) | (bus.in1_imm[1:0] == 2'b11);

  // Write accepted lanes into storage; flush drops same-cycle enqueues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_a[i]   <= '0;
        r_op[i]  <= '0;
        r_rd[i]  <= '0;
        r_ill[i] <= 1'b0;
      end
    end else if (!flush) begin
      if (w_enq0) begin
        r_a[r_wr_ptr]   <= bus.in0_rs1;
        r_op[r_wr_ptr]  <= bus.in0_imm[1:0];
        r_rd[r_wr_ptr]  <= bus.in0_rd;
        r_ill[r_wr_ptr] <= w_ill0;
      end
      if (w_enq1) begin
        r_a[w_wr_ptr1]   <= bus.in1_rs1;
        r_op[w_wr_ptr1]  <= bus.in1_imm[1:0];
        r_rd[w_wr_ptr1]  <= bus.in1_rd;
        r_ill[w_wr_ptr1] <= w_ill1;
      end
    end
  end

  // Advance pointers (modulo DEPTH by natural wrap) and track occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_enq_cnt);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_deq);
      r_occ    <= r_occ + CNT_W'(w_enq_cnt) - CNT_W'(w_deq);
    end
  end

  // Head entry is read straight out of storage: no extra issue latency.
  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_a       = r_a[r_rd_ptr];
  assign bus.out_op      = r_op[r_rd_ptr];
  assign bus.out_rd      = r_rd[r_rd_ptr];
  assign bus.out_illegal = r_ill[r_rd_ptr];
  assign bus.occupancy   = r_occ;
endmodule

// File: tb/tb_count_issue_queue.sv
// tb/tb_count_issue_queue.sv - scoreboard bench for count_issue_queue
module tb_count_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  typedef struct {
    logic [31:0]      a;
    logic [1:0]       op;
    logic [TAG_W-1:0] rd;
    logic             ill;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   failures;
  exp_t sb[$];

  count_issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  count_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t dec(input logic [31:0] rs1, input logic [11:0] imm,
                               input logic [TAG_W-1:0] rd);
    exp_t e;
    e.a   = rs1;
    e.op  = imm[1:0];
    e.rd  = rd;
    e.ill = (imm[11:2] != 10'h180) || (imm[1:0] == 2'b11);
    return e;
  endfunction

  task automatic set_lanes(input logic v0, input logic [11:0] imm0, input logic [31:0] rs0,
                           input logic [TAG_W-1:0] rd0, input logic v1, input logic [11:0] imm1,
                           input logic [31:0] rs1, input logic [TAG_W-1:0] rd1);
    bus.in0_valid = v0; bus.in0_imm = imm0; bus.in0_rs1 = rs0; bus.in0_rd = rd0;
    bus.in1_valid = v1; bus.in1_imm = imm1; bus.in1_rs1 = rs1; bus.in1_rd = rd1;
  endtask

  task automatic idle_lanes();
    set_lanes(1'b0, 12'h0, 32'h0, '0, 1'b0, 12'h0, 32'h0, '0);
  endtask

  // Check the DUT against the scoreboard at mid-cycle, update the model, then
  // advance one clock and return at the next falling edge.
  task automatic cycle();
    int n;
    n = sb.size();
    chk("in_ready", 32'(bus.in_ready), 32'(n <= DEPTH - 2));
    chk("out_valid", 32'(bus.out_valid), 32'(n != 0));
    chk("occupancy", 32'(bus.occupancy), 32'(n));
    if (n != 0) begin
      chk("out_a", bus.out_a, sb[0].a);
      chk("out_op", 32'(bus.out_op), 32'(sb[0].op));
      chk("out_rd", 32'(bus.out_rd), 32'(sb[0].rd));
      chk("out_illegal", 32'(bus.out_illegal), 32'(sb[0].ill));
    end
    if (flush) begin
      sb.delete();
    end else begin
      if (n != 0 && bus.out_ready) void'(sb.pop_front());
      if (n <= DEPTH - 2) begin
        if (bus.in0_valid) sb.push_back(dec(bus.in0_rs1, bus.in0_imm, bus.in0_rd));
        if (bus.in1_valid) sb.push_back(dec(bus.in1_rs1, bus.in1_imm, bus.in1_rd));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [11:0] imm_tab [5];

  initial begin
    checks   = 0;
    failures = 0;
    imm_tab[0] = 12'h600; imm_tab[1] = 12'h601; imm_tab[2] = 12'h602;
    imm_tab[3] = 12'h603; imm_tab[4] = 12'h400;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    idle_lanes();
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
    chk("rst_out_a", bus.out_a, 32'd0);
    chk("rst_out_op", 32'(bus.out_op), 32'd0);
    chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
    chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: lane 0 alone, visible the cycle after the write, gone the cycle after
    bus.out_ready = 1'b1;
    set_lanes(1'b1, 12'h600, 32'h0000_00FF, 5'd3, 1'b0, 12'h0, 32'h0, '0);
    cycle();
    idle_lanes();
    chk("t1_out_a", bus.out_a, 32'h0000_00FF);
    chk("t1_out_rd", 32'(bus.out_rd), 32'd3);
    cycle();
    cycle();

    // 2: dual enqueue held, then issued in lane order
    bus.out_ready = 1'b0;
    set_lanes(1'b1, 12'h601, 32'h1111_0000, 5'd1, 1'b1, 12'h602, 32'h2222_0000, 5'd2);
    cycle();
    idle_lanes();
    chk("t2_occupancy", 32'(bus.occupancy), 32'd2);
    cycle();
    cycle();
    bus.out_ready = 1'b1;
    cycle();
    chk("t2_second_rd", 32'(bus.out_rd), 32'd2);
    cycle();
    cycle();

    // 3: fill to full, ignored valids, in_ready returns only at two free slots
    bus.out_ready = 1'b0;
    set_lanes(1'b1, 12'h600, 32'hA0, 5'd10, 1'b1, 12'h601, 32'hA1, 5'd11);
    cycle();
    set_lanes(1'b1, 12'h602, 32'hA2, 5'd12, 1'b1, 12'h600, 32'hA3, 5'd13);
    cycle();
    chk("t3_full", 32'(bus.occupancy), 32'd4);
    set_lanes(1'b1, 12'h600, 32'hBAD0, 5'd30, 1'b1, 12'h600, 32'hBAD1, 5'd31);
    cycle();
    bus.out_ready = 1'b1;
    cycle();
    idle_lanes();
    chk("t3_occ3_not_ready", 32'(bus.in_ready), 32'd0);
    cycle();
    chk("t3_occ2_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) cycle();

    // 4: random lanes / out_ready, wrap around with simultaneous push and pop
    for (int i = 0; i < 20; i++) begin
      set_lanes(1'($urandom_range(0, 1)), imm_tab[$urandom_range(0, 4)], $urandom,
                TAG_W'($urandom), 1'($urandom_range(0, 1)), imm_tab[$urandom_range(0, 4)],
                $urandom, TAG_W'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle_lanes();
    bus.out_ready = 1'b1;
    repeat (5) cycle();

    // 5: malformed imm still enqueued and issued in order
    bus.out_ready = 1'b0;
    set_lanes(1'b1, 12'h603, 32'hC0DE_0001, 5'd5, 1'b1, 12'h400, 32'hC0DE_0002, 5'd6);
    cycle();
    idle_lanes();
    chk("t5_op_reserved", 32'(bus.out_op), 32'd3);
    chk("t5_illegal_op", 32'(bus.out_illegal), 32'd1);
    bus.out_ready = 1'b1;
    cycle();
    chk("t5_illegal_imm", 32'(bus.out_illegal), 32'd1);
    chk("t5_illegal_rd", 32'(bus.out_rd), 32'd6);
    cycle();
    cycle();

    // 6a: flush at occupancy 3 with a dual push pending
    bus.out_ready = 1'b0;
    set_lanes(1'b1, 12'h600, 32'hD0, 5'd20, 1'b1, 12'h601, 32'hD1, 5'd21);
    cycle();
    set_lanes(1'b1, 12'h602, 32'hD2, 5'd22, 1'b0, 12'h0, 32'h0, '0);
    cycle();
    chk("t6_occ3", 32'(bus.occupancy), 32'd3);
    set_lanes(1'b1, 12'h600, 32'hE0, 5'd23, 1'b1, 12'h600, 32'hE1, 5'd24);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    cycle();
    // flush on an empty queue also discards an acceptable dual push
    cycle();
    flush = 1'b0;
    idle_lanes();
    chk("t6_flush_occ", 32'(bus.occupancy), 32'd0);
    chk("t6_flush_valid", 32'(bus.out_valid), 32'd0);
    cycle();

    // 6b: asynchronous reset between clock edges
    bus.out_ready = 1'b0;
    set_lanes(1'b1, 12'h601, 32'hF0, 5'd25, 1'b1, 12'h602, 32'hF1, 5'd26);
    cycle();
    idle_lanes();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_occ", 32'(bus.occupancy), 32'd0);
    chk("t6_rst_ready", 32'(bus.in_ready), 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/count_issue_queue.md
Name: count_issue_queue

Overview:
- Upstream feeder for the Zbb count unit (clz/ctz/cpop) in the RV32 superscalar execute path.
- Accepts up to two decoded OP-IMM count instructions per cycle, one per dispatch lane.
- Buffers them in order in a small FIFO and issues one per cycle to the count unit.
- Issue carries the rs1 operand, the 2-bit op select, the destination tag and an illegal flag.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- TAG_W, 5, width of the destination register tag.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush; empties the queue.
- in0_valid  in  1  lane 0 instruction valid (older lane).
- in0_rs1  in  32  lane 0 rs1 value.
- in0_imm  in  12  lane 0 imm[11:0] (instr[31:20]).
- in0_rd  in  TAG_W  lane 0 destination tag.
- in1_valid, in1_rs1, in1_imm, in1_rd  in  1/32/12/TAG_W  lane 1 (younger lane), same meaning as lane 0.
- in_ready  out  1  queue can accept both lanes this cycle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head this cycle.
- out_a  out  32  operand to the count unit.
- out_op  out  2  op select: 00 clz, 01 ctz, 10 cpop, 11 reserved.
- out_rd  out  TAG_W  destination tag of the head entry.
- out_illegal  out  1  head entry has a malformed imm.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (async, rst_n=0): rd/wr pointers 0; occupancy 0; all entry storage 0; out_valid 0; out_a/out_op/out_rd/out_illegal 0; in_ready 1.
- Decode per lane at enqueue:
  - op = imm[1:0].
  - illegal = (imm[11:2] != 10'b0110000000) or (imm[1:0]==2'b11).
  - An illegal entry is still enqueued, keeping its imm[1:0] as op.
- Enqueue:
  - Happens only when in_ready=1.
  - in_ready = (DEPTH - occupancy) >= 2, computed from registered occupancy only; no combinational path from out_ready.
  - Lane 0 is written before lane 1 when both are valid.
  - in1_valid without in0_valid is legal; lane 1 then takes the lone slot.
  - Valids presented while in_ready=0 are ignored; the dispatcher holds them.
- Dequeue:
  - Fires when out_valid & out_ready.
  - out_* are driven directly from the head storage entry (registered, zero-latency view).
  - out_a/out_op/out_rd/out_illegal stay stable while out_valid=1 and out_ready=0.
  - When out_valid=0, out_* hold the last value and are don't-care.
- Latency: an entry written at edge N is visible on out_* after edge N, if the queue was empty.
- Simultaneous enqueue and dequeue: occupancy_next = occupancy + enq_count - deq; both take effect in the same edge.
- Wrap-around: pointers are modulo DEPTH; full/empty come from occupancy, never from pointer compare.
- Full: occupancy==DEPTH, so in_ready=0. occupancy==DEPTH-1 also gives in_ready=0 (all-or-nothing lane acceptance).
- Empty: out_valid=0; out_ready is ignored.
- Flush:
  - Pointers and occupancy go to 0; same-cycle enqueue and dequeue are discarded.
  - out_valid is 0 after the edge.
  - Flush has priority over every other event.
- Reset asserted mid-operation clears everything immediately, with no dependence on clk.

Test Plan:
1. Reset, then lane 0 only: in0_imm=0x600, in0_rs1=0x0000_00FF, in0_rd=3, out_ready=1 -> next cycle out_valid=1, out_a=0x0000_00FF, out_op=00, out_rd=3, out_illegal=0; queue empty the cycle after.
2. Dual enqueue with out_ready=0: lane0 imm=0x601 rd=1, lane1 imm=0x602 rd=2 -> occupancy=2; out_rd=1 (op 01) issues first, then out_rd=2 (op 10), in order.
3. Fill: two dual pushes with out_ready=0 -> occupancy=4, in_ready=0; further valids ignored. One pop -> occupancy=3, in_ready still 0. Second pop -> in_ready=1.
4. Wrap and simultaneous push/pop: keep 2-3 entries in flight for 20 cycles with random lanes and out_ready -> issue order equals dispatch order (lane0 before lane1), occupancy matches the scoreboard, pointers wrap cleanly.
5. Illegal decode: imm=0x603 -> out_op=11, out_illegal=1. imm=0x400 -> out_illegal=1. Both are still issued in order.
6. Flush and reset: occupancy=3, assert flush together with a dual push -> occupancy=0, out_valid=0. Separately, drop rst_n between clock edges -> out_valid=0 and occupancy=0 immediately.
